// File: rtl/poly_chords.sv
// -----------------------------------------------------------------------------
// poly_chords : polyphonic note engine
//
// Takes notes from the song reader and places each into one of NUM_VOICES
// voice slots. A free slot (lowest index) is used when one exists; otherwise
// the oldest sounding voice is evicted. Each voice counts its duration down in
// beats. On each codec request every sounding voice produces one sample of its
// waveform and the voices are mixed into a single signed sample.
//
// Waveform generation:
//   - note ROM  : phase increment per request = note * 4 (10-bit phase wheel)
//   - sine read : parabolic sine; x = phase[8:0], |s| = (x*(512-x)*AMP) >> 16
//                 with AMP = 2^(SAMPLE_WIDTH-1)-1, negated when phase[9] = 1.
//                 The peak (x = 256) is exactly AMP.
//
// Ports:
//   i_clk                   system clock
//   i_reset                 synchronous, active-high reset
//   i_play                  1 = run, 0 = pause (voices frozen, samples = 0)
//   i_note                  note code (0 = rest), qualified by i_new_note
//   i_duration              duration in beats, qualified by i_new_note
//   i_new_note              1-cycle strobe: allocate a voice for i_note
//   i_beat                  1-cycle beat tick
//   i_generate_next_sample  1-cycle codec request
//   o_sample_out            signed mixed sample, held between strobes
//   o_new_sample_ready      1-cycle strobe, two cycles after an accepted request
//   o_voices_active         bit i = voice slot i sounding
//   o_voice_stolen          1-cycle strobe: last allocation evicted a voice
// -----------------------------------------------------------------------------
module poly_chords #(
    parameter int NUM_VOICES   = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int NOTE_WIDTH   = 6,
    parameter int DUR_WIDTH    = 6,
    parameter int MIX_MODE     = 0
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_play,
    input  logic [NOTE_WIDTH-1:0]          i_note,
    input  logic [DUR_WIDTH-1:0]           i_duration,
    input  logic                           i_new_note,
    input  logic                           i_beat,
    input  logic                           i_generate_next_sample,
    output logic signed [SAMPLE_WIDTH-1:0] o_sample_out,
    output logic                           o_new_sample_ready,
    output logic [NUM_VOICES-1:0]          o_voices_active,
    output logic                           o_voice_stolen
);

    localparam int VIDX_W  = $clog2(NUM_VOICES);
    localparam int PHASE_W = 10;
    localparam int SUM_W   = SAMPLE_WIDTH + VIDX_W;
    localparam logic [47:0] AMP = 48'((64'd1 << (SAMPLE_WIDTH - 1)) - 64'd1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(AMP);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    // Note ROM: phase increment for one sample request.
    function automatic logic [PHASE_W-1:0] note_step(input logic [NOTE_WIDTH-1:0] note);
        return PHASE_W'({note, 2'b00});
    endfunction

    // Sine reader: parabolic approximation of one sine period over the phase wheel.
    function automatic logic signed [SAMPLE_WIDTH-1:0] sine_lookup(input logic [PHASE_W-1:0] ph);
        logic [47:0]             y;
        logic [SAMPLE_WIDTH-1:0] mag;
        y   = 48'(ph[8:0]) * (48'd512 - 48'(ph[8:0]));
        mag = SAMPLE_WIDTH'((y * AMP) >> 16);
        if (ph[9]) begin
            return -$signed(mag);
        end else begin
            return $signed(mag);
        end
    endfunction

    // Per-slot state
    logic [NUM_VOICES-1:0]          r_valid;
    logic [NOTE_WIDTH-1:0]          r_note  [NUM_VOICES];
    logic [DUR_WIDTH-1:0]           r_rem   [NUM_VOICES];
    logic [2:0]                     r_age   [NUM_VOICES];
    logic [PHASE_W-1:0]             r_phase [NUM_VOICES];
    logic                           r_stolen;

    // Sample pipeline
    logic                           r_stage1;
    logic signed [SAMPLE_WIDTH-1:0] r_vsmp  [NUM_VOICES];
    logic signed [SAMPLE_WIDTH-1:0] r_sample_out;
    logic                           r_ready;

    // Combinational helpers
    logic                           w_alloc;
    logic                           w_req;
    logic                           w_has_free;
    logic [VIDX_W-1:0]              w_free_idx;
    logic [VIDX_W-1:0]              w_old_idx;
    logic [2:0]                     w_old_age;
    logic [VIDX_W-1:0]              w_target;
    logic signed [SUM_W-1:0]        w_sum;
    logic signed [SAMPLE_WIDTH-1:0] w_mix;

    assign w_alloc  = i_new_note & i_play & (i_note != '0) & (i_duration != '0);
    // A request arriving while the previous one is still in flight is dropped.
    assign w_req    = i_generate_next_sample & ~r_stage1;
    assign w_target = w_has_free ? w_free_idx : w_old_idx;

    // Victim search: lowest free slot, else oldest slot (ties go to lowest index).
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            w_free_idx = r_valid[i] ? w_free_idx : VIDX_W'(i);
            w_has_free = w_has_free | ~r_valid[i];
        end
        w_old_idx = '0;
        w_old_age = r_age[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            w_old_idx = (r_age[i] > w_old_age) ? VIDX_W'(i) : w_old_idx;
            w_old_age = (r_age[i] > w_old_age) ? r_age[i]   : w_old_age;
        end
    end

    // Mixer: widened signed sum, then average or saturate.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_sum = w_sum + {{VIDX_W{r_vsmp[i][SAMPLE_WIDTH-1]}}, r_vsmp[i]};
        end
        if (MIX_MODE == 0) begin
            // Arithmetic shift then truncate is exactly the upper slice.
            w_mix = w_sum[VIDX_W +: SAMPLE_WIDTH];
        end else if (w_sum > SAT_MAX) begin
            w_mix = SAT_MAX[SAMPLE_WIDTH-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_mix = SAT_MIN[SAMPLE_WIDTH-1:0];
        end else begin
            w_mix = w_sum[SAMPLE_WIDTH-1:0];
        end
    end

    // Voice slot state: allocation, ageing, beat countdown, phase advance.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid  <= '0;
            r_stolen <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i]  <= '0;
                r_rem[i]   <= '0;
                r_age[i]   <= 3'd0;
                r_phase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (w_alloc && (w_target == VIDX_W'(i))) begin
                    // Freshly loaded slot ignores this cycle's beat and phase step.
                    r_valid[i] <= 1'b1;
                    r_note[i]  <= i_note;
                    r_rem[i]   <= i_duration;
                    r_age[i]   <= 3'd0;
                    r_phase[i] <= '0;
                end else begin
                    if (w_alloc && r_valid[i] && (r_age[i] != 3'd7)) begin
                        r_age[i] <= r_age[i] + 3'd1;
                    end
                    if (i_beat && i_play && r_valid[i]) begin
                        r_rem[i] <= r_rem[i] - DUR_WIDTH'(1);
                        if (r_rem[i] == DUR_WIDTH'(1)) begin
                            r_valid[i] <= 1'b0;
                        end
                    end
                    if (w_req && i_play && r_valid[i]) begin
                        r_phase[i] <= r_phase[i] + note_step(r_note[i]);
                    end
                end
            end
            r_stolen <= w_alloc & ~w_has_free;
        end
    end

    // First pipeline stage: capture each voice's waveform sample.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stage1 <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_vsmp[i] <= '0;
            end
        end else begin
            r_stage1 <= w_req;
            if (w_req) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    r_vsmp[i] <= (i_play && r_valid[i]) ? sine_lookup(r_phase[i]) : '0;
                end
            end
        end
    end

    // Output stage: registered mix and ready strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sample_out <= '0;
            r_ready      <= 1'b0;
        end else begin
            r_ready <= r_stage1;
            if (r_stage1) begin
                r_sample_out <= w_mix;
            end
        end
    end

    assign o_sample_out       = r_sample_out;
    assign o_new_sample_ready = r_ready;
    assign o_voices_active    = r_valid;
    assign o_voice_stolen     = r_stolen;

endmodule

// File: tb/tb_poly_chords.sv
// -----------------------------------------------------------------------------
// tb_poly_chords : scoreboard bench for poly_chords.
// Two instances share all inputs: one averaging mixer, one saturating mixer.
// A behavioural model advances once per clock edge and queues the expected
// slot occupancy / steal flag and each expected mixed sample with its arrival
// edge; a monitor pops and compares shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_poly_chords;

    logic        clk = 1'b0;
    logic        rst, play, new_note, beat, gen;
    logic [5:0]  note, dur;

    logic signed [15:0] s0_out, s1_out;
    logic               rdy0, rdy1, stl0, stl1;
    logic [3:0]         act0, act1;

    poly_chords #(.MIX_MODE(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_play(play), .i_note(note), .i_duration(dur),
        .i_new_note(new_note), .i_beat(beat), .i_generate_next_sample(gen),
        .o_sample_out(s0_out), .o_new_sample_ready(rdy0),
        .o_voices_active(act0), .o_voice_stolen(stl0));

    poly_chords #(.MIX_MODE(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_play(play), .i_note(note), .i_duration(dur),
        .i_new_note(new_note), .i_beat(beat), .i_generate_next_sample(gen),
        .o_sample_out(s1_out), .o_new_sample_ready(rdy1),
        .o_voices_active(act1), .o_voice_stolen(stl1));

    always #5 clk = ~clk;

    typedef struct { int edge_no; logic [3:0] act; logic stolen; } st_t;
    typedef struct { int edge_no; int s0; int s1; } smp_t;

    st_t  stq[$];
    smp_t sq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    // Reference model state
    bit m_valid[4];
    int m_note[4], m_rem[4], m_age[4], m_phase[4];
    bit m_stage_v;
    int m_stage_sum;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // One sine period over 1024 phase steps, parabolic shape, peak 32767.
    function automatic int ref_wave(input int ph);
        int x = ph % 512;
        longint y = longint'(x) * longint'(512 - x);
        int mag = int'((y * 64'd32767) / 65536);
        return (ph >= 512) ? -mag : mag;
    endfunction

    function automatic int mix_avg(input int s);
        return s >>> 2;
    endfunction

    function automatic int mix_sat(input int s);
        if (s > 32767) return 32767;
        else if (s < -32768) return -32768;
        else return s;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        int   e = edge_cnt + 1;
        st_t  st;
        int   sum, tgt, oldest_age;
        int   freeq[$];
        bit   acc, alloc;
        st.stolen = 1'b0;
        if (rst) begin
            for (int v = 0; v < 4; v++) begin
                m_valid[v] = 0; m_note[v] = 0; m_rem[v] = 0; m_age[v] = 0; m_phase[v] = 0;
            end
            m_stage_v = 0;
        end else begin
            if (m_stage_v) sq.push_back('{e, mix_avg(m_stage_sum), mix_sat(m_stage_sum)});
            acc = gen && !m_stage_v;
            sum = 0;
            for (int v = 0; v < 4; v++)
                if (play && m_valid[v]) sum += ref_wave(m_phase[v]);
            alloc = new_note && play && (note != 0) && (dur != 0);
            for (int v = 0; v < 4; v++) if (!m_valid[v]) freeq.push_back(v);
            if (freeq.size() > 0) tgt = freeq[0];
            else begin
                tgt = 0; oldest_age = m_age[0];
                for (int v = 1; v < 4; v++)
                    if (m_age[v] > oldest_age) begin tgt = v; oldest_age = m_age[v]; end
            end
            for (int v = 0; v < 4; v++) begin
                if (alloc && v == tgt) begin
                    m_valid[v] = 1; m_note[v] = note; m_rem[v] = dur; m_age[v] = 0; m_phase[v] = 0;
                end else if (m_valid[v]) begin
                    if (acc && play) m_phase[v] = (m_phase[v] + 4 * m_note[v]) % 1024;
                    if (alloc && m_age[v] < 7) m_age[v]++;
                    if (beat && play) begin
                        m_rem[v]--;
                        if (m_rem[v] == 0) m_valid[v] = 0;
                    end
                end
            end
            st.stolen = alloc && (freeq.size() == 0);
            m_stage_v = acc;
            if (acc) m_stage_sum = sum;
        end
        st.edge_no = e;
        for (int v = 0; v < 4; v++) st.act[v] = m_valid[v];
        stq.push_back(st);
    endtask

    // Commit current inputs to the model, run one clock, clear strobes.
    task automatic step();
        model_edge();
        @(negedge clk);
        new_note = 1'b0; beat = 1'b0; gen = 1'b0;
    endtask

    task automatic put_note(input int n, input int d);
        note = 6'(n); dur = 6'(d); new_note = 1'b1;
        step();
    endtask

    task automatic request();
        gen = 1'b1;
        step(); step(); step();
    endtask

    // Monitor: compare outputs 1 time unit after each rising edge.
    always @(posedge clk) begin
        st_t  st;
        smp_t sm;
        edge_cnt++;
        #1;
        if (stq.size() > 0) begin
            st = stq.pop_front();
            chk("voices_active_avg", int'(act0), int'(st.act));
            chk("voices_active_sat", int'(act1), int'(st.act));
            chk("voice_stolen", int'(stl0), int'(st.stolen));
            chk("voice_stolen_sat", int'(stl1), int'(st.stolen));
        end
        if (rdy0 || rdy1) begin
            chk("ready_agree", int'(rdy1), int'(rdy0));
            if (sq.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                sm = sq.pop_front();
                chk("strobe_latency", edge_cnt, sm.edge_no);
                chk("sample_avg", int'(s0_out), sm.s0);
                chk("sample_sat", int'(s1_out), sm.s1);
            end
        end
    end

    initial begin
        rst = 1'b1; play = 1'b1; new_note = 1'b0; beat = 1'b0; gen = 1'b0;
        note = 6'd0; dur = 6'd0;
        step(); step(); step();
        chk("reset_sample", int'(s0_out), 0);
        chk("reset_ready", int'(rdy0), 0);
        rst = 1'b0;

        // 1: single note, four beats, requests
        put_note(37, 4);
        request();
        for (int b = 0; b < 4; b++) begin beat = 1'b1; step(); end
        request();

        // 2: four notes fill all slots
        put_note(37, 20); put_note(41, 3); put_note(44, 20); put_note(49, 20);
        request(); request();

        // 3: fifth note steals oldest slot 0
        put_note(52, 20);
        request();

        // 4: slot 1 down to one beat left, then beat + new note together
        beat = 1'b1; step();
        beat = 1'b1; step();
        note = 6'd55; dur = 6'd10; new_note = 1'b1; beat = 1'b1; step();
        request();

        // 5: pause across three beats and a request, then resume
        play = 1'b0;
        for (int b = 0; b < 3; b++) begin beat = 1'b1; gen = (b == 1); step(); step(); end
        request();
        play = 1'b1;
        request();
        for (int b = 0; b < 3; b++) begin beat = 1'b1; step(); end
        request();

        // dropped back-to-back request
        gen = 1'b1; step(); gen = 1'b1; step(); step(); step();

        // 6: four in-phase voices at the waveform peaks -> saturation
        rst = 1'b1; step(); rst = 1'b0;
        for (int v = 0; v < 4; v++) put_note(32, 60);
        for (int k = 0; k < 7; k++) begin
            gen = 1'b1; step(); step();
            if (k == 2) chk("sat_positive", int'(s1_out), 32767);
            if (k == 6) chk("sat_negative", int'(s1_out), -32768);
            step();
        end
        gen = 1'b1; step();
        rst = 1'b1; step();
        rst = 1'b0; step();
        chk("no_strobe_after_reset", int'(rdy0), 0);
        step(); step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            play     = ($urandom_range(0, 9) != 0);
            new_note = ($urandom_range(0, 3) == 0);
            note     = 6'($urandom_range(0, 63));
            dur      = 6'($urandom_range(0, 12));
            beat     = ($urandom_range(0, 6) == 0);
            gen      = ($urandom_range(0, 2) == 0);
            step();
        end
        rst = 1'b0; play = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("pending_samples", sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
